// File: rtl/sha_w_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha_w_stream_if
//  Purpose  : Block-load and schedule-word handshake bundle for sha_w_stream.
//  Revision : 1.0 - initial release
// ============================================================================
interface sha_w_stream_if #(
    parameter int WORD_S = 32
) ();
    logic [16*WORD_S-1:0] M;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_S-1:0]    w_out;
    logic [6:0]           w_idx;
    logic                 w_valid;
    logic                 w_ready;
    logic                 w_last;

    modport master (
        output M, in_valid, w_ready,
        input  in_ready, w_out, w_idx, w_valid, w_last
    );

    modport slave (
        input  M, in_valid, w_ready,
        output in_ready, w_out, w_idx, w_valid, w_last
    );
endinterface
`default_nettype wire

// File: rtl/sha_w_stream.sv
`default_nettype none
// ============================================================================
//  Module   : sha_w_stream
//  Purpose  : Streaming SHA-256/512 message schedule with a 16-word window.
//  Revision : 1.0 - initial release
// ============================================================================
module sha_w_stream #(
    parameter int WORD_S = 32,
    parameter int ROUNDS = 64
) (
    input  wire logic       clk,
    input  wire logic       reset,
    sha_w_stream_if.slave   bus
);

    localparam logic [6:0] c_LAST_IDX = 7'(ROUNDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [WORD_S-1:0] r_win [16];
    logic [6:0]        r_t;
    logic              r_in_ready;
    logic              r_w_valid;
    logic              r_w_last;

    logic [WORD_S-1:0] w_sig0;
    logic [WORD_S-1:0] w_sig1;
    logic [WORD_S-1:0] w_next;

    // sig0 acts on W[t+1] (win[1]), sig1 on W[t+14] (win[14])
    generate
        if (WORD_S == 64) begin : g_sig64
            assign w_sig0 = {r_win[1][0],     r_win[1][63:1]}
                          ^ {r_win[1][7:0],   r_win[1][63:8]}
                          ^ (r_win[1] >> 7);
            assign w_sig1 = {r_win[14][18:0], r_win[14][63:19]}
                          ^ {r_win[14][60:0], r_win[14][63:61]}
                          ^ (r_win[14] >> 6);
        end else begin : g_sig32
            assign w_sig0 = {r_win[1][6:0],   r_win[1][31:7]}
                          ^ {r_win[1][17:0],  r_win[1][31:18]}
                          ^ (r_win[1] >> 3);
            assign w_sig1 = {r_win[14][16:0], r_win[14][31:17]}
                          ^ {r_win[14][18:0], r_win[14][31:19]}
                          ^ (r_win[14] >> 10);
        end
    endgenerate

    assign w_next = w_sig1 + r_win[9] + w_sig0 + r_win[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_in_ready <= 1'b1;
            r_w_valid  <= 1'b0;
            r_w_last   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            r_win[i] <= bus.M[(16-i)*WORD_S-1 -: WORD_S];
                        end
                        r_t        <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_w_valid  <= 1'b1;
                        r_w_last   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.w_ready) begin
                        if (r_t == c_LAST_IDX) begin
                            r_state    <= S_IDLE;
                            r_t        <= '0;
                            r_in_ready <= 1'b1;
                            r_w_valid  <= 1'b0;
                            r_w_last   <= 1'b0;
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                r_win[i] <= r_win[i+1];
                            end
                            r_win[15] <= w_next;
                            r_t       <= r_t + 7'd1;
                            r_w_last  <= (r_t == c_LAST_IDX - 7'd1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.w_valid  = r_w_valid;
    assign bus.w_last   = r_w_last;
    assign bus.w_idx    = r_t;
    assign bus.w_out    = r_win[0];

endmodule
`default_nettype wire

// File: tb/tb_sha_w_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha_w_stream
//  Purpose  : Self-checking bench for sha_w_stream (SHA-256 and SHA-512 builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha_w_stream;

    logic    clk   = 1'b0;
    logic    reset = 1'b0;
    longint  cyc   = 0;
    int      checks   = 0;
    int      failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha_w_stream_if #(.WORD_S(32)) bus32 ();
    sha_w_stream_if #(.WORD_S(64)) bus64 ();

    sha_w_stream #(.WORD_S(32), .ROUNDS(64)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    sha_w_stream #(.WORD_S(64), .ROUNDS(80)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    logic [63:0] exp_w [128];
    logic [63:0] obs_w [128];

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Textbook recurrence over the full W array
    task automatic build_model(input logic [1023:0] blk, input bit is64, input int rounds);
        logic [31:0] a, b, s;
        for (int t = 0; t < rounds; t++) begin
            if (t < 16) begin
                if (is64) exp_w[t] = blk[(16-t)*64-1 -: 64];
                else      exp_w[t] = {32'b0, blk[(16-t)*32-1 -: 32]};
            end else if (is64) begin
                exp_w[t] = (r64(exp_w[t-2], 19) ^ r64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6))
                         + exp_w[t-7]
                         + (r64(exp_w[t-15], 1) ^ r64(exp_w[t-15], 8) ^ (exp_w[t-15] >> 7))
                         + exp_w[t-16];
            end else begin
                a = exp_w[t-2][31:0];
                b = exp_w[t-15][31:0];
                s = (r32(a, 17) ^ r32(a, 19) ^ (a >> 10))
                  + exp_w[t-7][31:0]
                  + (r32(b, 7) ^ r32(b, 18) ^ (b >> 3))
                  + exp_w[t-16][31:0];
                exp_w[t] = {32'b0, s};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input bit is64, output logic [63:0] o, output logic [6:0] idx,
                           output logic v, output logic l, output logic r);
        if (is64) begin
            o = bus64.w_out; idx = bus64.w_idx; v = bus64.w_valid;
            l = bus64.w_last; r = bus64.in_ready;
        end else begin
            o = {32'b0, bus32.w_out}; idx = bus32.w_idx; v = bus32.w_valid;
            l = bus32.w_last; r = bus32.in_ready;
        end
    endtask

    task automatic set_m(input bit is64, input logic [1023:0] blk);
        if (is64) bus64.M = blk;
        else      bus32.M = blk[511:0];
    endtask

    task automatic set_valid(input bit is64, input logic v);
        if (is64) bus64.in_valid = v;
        else      bus32.in_valid = v;
    endtask

    task automatic set_ready(input bit is64, input logic v);
        if (is64) bus64.w_ready = v;
        else      bus32.w_ready = v;
    endtask

    task automatic accept(input bit is64, input logic [1023:0] blk, input bit keep,
                          output longint acc);
        logic [63:0] o; logic [6:0] idx; logic v, l, r;
        int n = 0;
        observe(is64, o, idx, v, l, r);
        while (r !== 1'b1 && n < 200) begin
            step();
            observe(is64, o, idx, v, l, r);
            n++;
        end
        checks++;
        if (r !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait: in_ready=%b required 1", r);
        end
        set_m(is64, blk);
        set_valid(is64, 1'b1);
        step();
        acc = cyc;
        if (!keep) set_valid(is64, 1'b0);
    endtask

    task automatic drain(input bit is64, input int rounds, input bit rnd, input int abort_at,
                         input bit chg, input logic [1023:0] chg_m, input string name);
        logic [63:0] o; logic [6:0] idx; logic v, l, r;
        bit rb;
        int e = 0;
        int budget = 0;
        while (e < rounds && budget < 4000) begin
            observe(is64, o, idx, v, l, r);
            checks++;
            if (v !== 1'b1 || r !== 1'b0) begin
                failures++;
                $display("FAIL %s_valid: t=%0d w_valid=%b in_ready=%b required 1/0", name, e, v, r);
            end
            checks++;
            if (idx !== 7'(e)) begin
                failures++;
                $display("FAIL %s_idx: w_idx=%0d required %0d", name, idx, e);
            end
            checks++;
            if (o !== exp_w[e]) begin
                failures++;
                $display("FAIL %s_word: t=%0d w_out=%h required %h", name, e, o, exp_w[e]);
            end
            checks++;
            if (l !== (e == rounds - 1)) begin
                failures++;
                $display("FAIL %s_last: t=%0d w_last=%b required %b", name, e, l, (e == rounds - 1));
            end
            if (abort_at == e) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                return;
            end
            if (chg && e == 5) set_m(is64, chg_m);
            rb = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            set_ready(is64, rb);
            step();
            if (rb && v === 1'b1) begin
                obs_w[e] = o;
                e++;
            end
            budget++;
        end
        checks++;
        if (e < rounds) begin
            failures++;
            $display("FAIL %s_timeout: words=%0d required %0d", name, e, rounds);
        end
        observe(is64, o, idx, v, l, r);
        checks++;
        if (r !== 1'b1 || v !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_last: in_ready=%b w_valid=%b required 1/0", name, r, v);
        end
    endtask

    function automatic logic [1023:0] rand_blk();
        logic [1023:0] b;
        for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic check_idle_reset(input bit is64, input string name);
        logic [63:0] o; logic [6:0] idx; logic v, l, r;
        observe(is64, o, idx, v, l, r);
        checks++;
        if (r !== 1'b1 || v !== 1'b0 || l !== 1'b0 || idx !== 7'd0 || o !== 64'd0) begin
            failures++;
            $display("FAIL %s: in_ready=%b w_valid=%b w_last=%b w_idx=%0d w_out=%h required 1/0/0/0/0",
                     name, r, v, l, idx, o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step(); step();
        check_idle_reset(1'b0, "reset32");
        check_idle_reset(1'b1, "reset64");
        reset = 1'b1;
        step();
        check_idle_reset(1'b0, "reset32_released");
    endtask

    task automatic run_full(input bit is64, input logic [1023:0] blk, input bit rnd, input string name);
        longint acc;
        int rounds = is64 ? 80 : 64;
        build_model(blk, is64, rounds);
        accept(is64, blk, 1'b0, acc);
        drain(is64, rounds, rnd, -1, 1'b0, '0, name);
    endtask

    task automatic test_abc32();
        logic [1023:0] blk = '0;
        blk[511:480] = 32'h61626380;
        blk[31:0]    = 32'h00000018;
        run_full(1'b0, blk, 1'b0, "abc32");
        checks++;
        if (obs_w[0] !== 64'h61626380 || obs_w[15] !== 64'h18) begin
            failures++;
            $display("FAIL abc32_msg: W0=%h W15=%h required 61626380/00000018", obs_w[0], obs_w[15]);
        end
        checks++;
        if (obs_w[16] !== 64'h61626380 || obs_w[17] !== 64'h000F0000) begin
            failures++;
            $display("FAIL abc32_sched: W16=%h W17=%h required 61626380/000f0000", obs_w[16], obs_w[17]);
        end
    endtask

    task automatic test_stall32();
        logic [1023:0] blk = '0;
        blk[511:480] = 32'h61626380;
        blk[31:0]    = 32'h00000018;
        run_full(1'b0, blk, 1'b1, "stall32");
    endtask

    task automatic test_abc64();
        logic [1023:0] blk = '0;
        blk[1023:960] = 64'h6162638000000000;
        blk[63:0]     = 64'h18;
        run_full(1'b1, blk, 1'b0, "abc64");
        checks++;
        if (obs_w[16] !== 64'h6162638000000000) begin
            failures++;
            $display("FAIL abc64_w16: W16=%h required 6162638000000000", obs_w[16]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1023:0] a = rand_blk();
        logic [1023:0] b = rand_blk();
        logic [1023:0] c = rand_blk();
        longint acc_a, acc_b;
        set_ready(1'b0, 1'b1);
        build_model(a, 1'b0, 64);
        accept(1'b0, a, 1'b1, acc_a);
        drain(1'b0, 64, 1'b0, -1, 1'b1, b, "b2b_first");
        build_model(b, 1'b0, 64);
        accept(1'b0, b, 1'b0, acc_b);
        set_m(1'b0, c);
        checks++;
        if (acc_b - acc_a !== 64'd65) begin
            failures++;
            $display("FAIL b2b_period: cycles=%0d required 65", acc_b - acc_a);
        end
        drain(1'b0, 64, 1'b0, -1, 1'b0, '0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        logic [1023:0] a = rand_blk();
        longint acc;
        build_model(a, 1'b0, 64);
        accept(1'b0, a, 1'b0, acc);
        drain(1'b0, 64, 1'b0, 20, 1'b0, '0, "mid_pre");
        check_idle_reset(1'b0, "mid_reset");
        step();
        check_idle_reset(1'b0, "mid_reset_hold");
        run_full(1'b0, rand_blk(), 1'b0, "mid_post");
    endtask

    task automatic test_patterns();
        logic [1023:0] ones = '1;
        logic [1023:0] alt;
        for (int i = 0; i < 64; i++) alt[i*16 +: 16] = (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
        run_full(1'b0, ones, 1'b0, "ones32");
        run_full(1'b1, ones, 1'b1, "ones64");
        run_full(1'b0, alt, 1'b1, "alt32");
        run_full(1'b1, alt, 1'b0, "alt64");
        for (int k = 0; k < 3; k++) begin
            run_full(1'b0, rand_blk(), 1'b1, "rand32");
            run_full(1'b1, rand_blk(), 1'b1, "rand64");
        end
    endtask

    initial begin
        bus32.M = '0; bus32.in_valid = 1'b0; bus32.w_ready = 1'b0;
        bus64.M = '0; bus64.in_valid = 1'b0; bus64.w_ready = 1'b0;
        test_reset();
        test_abc32();
        test_stall32();
        test_abc64();
        test_back_to_back();
        test_reset_mid();
        test_patterns();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha_w_stream.md
# sha_w_stream

Parametrised, streaming SHA-2 message-schedule generator. It accepts one 16-word padded message block and emits the schedule words W_0..W_{ROUNDS-1} one per handshake, in order, over a valid/ready interface. It keeps a rolling 16-word window instead of a full W array. It sits between the block padder/loader and the round-compression core, and supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) with the same RTL.

## Interface
Parameters:
- WORD_S, 32: word width; legal values are 32 (SHA-256 sigma set) and 64 (SHA-512 sigma set).
- ROUNDS, 64: number of schedule words emitted per block; 64 for WORD_S=32, 80 for WORD_S=64; legal range 16..127.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk, asserted when 0.
- M  input  16*WORD_S  message block; word 0 at M[16*WORD_S-1 -: WORD_S], word 15 at M[WORD_S-1:0].
- in_valid  input  1  M is valid.
- in_ready  output  1  block accepted on in_valid & in_ready.
- w_out  output  WORD_S  current schedule word W_t.
- w_idx  output  7  index t of w_out.
- w_valid  output  1  w_out/w_idx/w_last are valid.
- w_ready  input  1  consumer takes the word on w_valid & w_ready.
- w_last  output  1  high with w_valid when t = ROUNDS-1.

## Operation
- Two states: IDLE and RUN.
- IDLE: in_ready=1, w_valid=0. On in_valid=1, load the window win[0..15] with M words 0..15, set t=0, and go to RUN.
- RUN: in_ready=0, w_valid=1, w_out=win[0], w_idx=t, w_last=(t==ROUNDS-1).
- On a handshake in RUN with t<ROUNDS-1: shift the window down by one (win[i]<=win[i+1]), set win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0] mod 2^WORD_S, and set t<=t+1.
- On a handshake in RUN with t=ROUNDS-1: go to IDLE. The window contents are don't-care afterwards.
- Sigma functions for WORD_S=32: sig0 = ROTR7^ROTR18^SHR3; sig1 = ROTR17^ROTR19^SHR10.
- Sigma functions for WORD_S=64: sig0 = ROTR1^ROTR8^SHR7; sig1 = ROTR19^ROTR61^SHR6.
- All additions wrap modulo 2^WORD_S. No carry out.
- For t<16 the emitted words are the unmodified message words.
- Stall (w_valid=1, w_ready=0): w_out, w_idx, w_last and the window hold exactly. No word is skipped or repeated.
- in_valid is ignored in RUN. M is only sampled on the accepting edge, so it may change afterwards.
- Reset (reset=0 at a clock edge), including mid-block: state=IDLE, t=0, w_valid=0, w_last=0, w_idx=0, w_out=0. The partial block is discarded and nothing further is emitted for it.
- Reset values: in_ready=1 in the cycle after reset, w_valid=0, w_last=0, w_idx=0, w_out=0.

## Timing
- Accept-to-first-word latency is 1 cycle: W_0 is valid in the cycle after the accepting edge.
- Throughput is 1 word/cycle with w_ready held at 1. A block occupies ROUNDS cycles of RUN.
- After the w_last handshake, in_ready=1 in the next cycle. The minimum block-to-block period is ROUNDS+1 cycles.
- Critical path is one 4-operand WORD_S adder plus two sigma XOR trees. All outputs are registered or decoded from state registers only.
- in_ready and w_valid are never both 1.

## Test plan
- SHA-256 "abc" block (word 0=0x61626380, words 1..14=0, word 15=0x00000018), w_ready=1.
  - Required: W_0=0x61626380 with w_idx=0, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000.
  - Required: exactly 64 words, w_last only on w_idx=63, in_ready=1 in the following cycle.
- Same block with w_ready toggled pseudo-randomly.
  - Required: the sequence is identical to the previous scenario, and outputs are stable on every stalled cycle.
- WORD_S=64, ROUNDS=80, "abc" block (word 0=0x6162638000000000, word 15=0x18).
  - Required: W_16=0x6162638000000000, 80 words, w_last at w_idx=79.
  - Required: all 80 words match the reference model.
- Back-to-back blocks with in_valid held high and M changed during RUN.
  - Required: the second block's W_0 appears ROUNDS+1 cycles after the first accept (w_ready=1).
  - Required: the second block's contents are those sampled at its own accept edge.
- Reset driven to 0 at w_idx=20.
  - Required: the next cycle has w_valid=0 and in_ready=1.
  - Required: a newly accepted block starts at w_idx=0 with correct words.
- Randomised all-ones and alternating-pattern blocks (0xFFFFFFFF..., 0xAAAA5555...).
  - Required: all words match the software model, and wrap-around additions are correct.
